lcd_rx_decoder: RTL
===================

Name: lcd_rx_decoder

Overview:
Receiving end of the 4-bit HD44780-style LCD write interface our display driver produces. Monitors lcd_rs/lcd_w/lcd_e/data on the system clock and captures a nibble on each falling edge of lcd_e. Assembles nibbles into command and data bytes, executes the command subset the driver uses, and keeps a shadow DDRAM of two 16-character lines. The 128-bit line outputs mirror the driver's line1/line2 inputs, for loopback checking and on-board echo.

Parameters:
FILL_CHAR, 8'h20, character written to every cell on reset and on Clear Display
LINE2_BASE, 7'h40, DDRAM address of the first character of line 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
lcd_rs  input  1  register select: 0 = command, 1 = data
lcd_w  input  1  read/write: 0 = write; 1 = read, which is unsupported
lcd_e  input  1  enable strobe; nibble latched on its falling edge
data  input  4  nibble bus
line1  output  128  line 1 characters; char 0 at [127:120], char 15 at [7:0]
line2  output  128  line 2 characters, same packing
addr  output  7  DDRAM address counter
display_on  output  1  D bit of the last Display Control command
four_bit  output  1  1 once the interface has switched to 4-bit mode
byte_out  output  8  last completed byte
cmd_valid  output  1  one-cycle pulse: command byte completed
data_valid  output  1  one-cycle pulse: data byte completed
rd_err  output  1  sticky: a nibble was strobed with lcd_w=1

Behaviour:
- Reset (async, rst_n=0): both lines filled with FILL_CHAR; addr=0; display_on=0; four_bit=0; byte_out=0; pulses=0; rd_err=0; e_q=0; FSM=INIT8; entry increment=1.
- Edge detect: e_q registers lcd_e. A strobe is the clock edge where e_q=1 and lcd_e=0. On that edge the sampled lcd_rs, lcd_w and data are used. Any result, including the pulses, is visible in the following cycle (1-cycle latency). No metastability synchroniser: the inputs are synchronous to clk.
- A strobe with lcd_w=1 sets rd_err and is otherwise ignored; it does not advance the FSM.
- FSM INIT8 (8-bit mode): each strobe is a whole command, taken as {data,4'h0}.
  - rs=0 and data=4'h3: stay in INIT8.
  - rs=0 and data=4'h2: set four_bit=1 and go to HI.
  - Any other strobe in INIT8 is ignored.
  - No pulses are generated in INIT8.
- FSM HI: store the nibble as the high half, go to LO.
- FSM LO: byte = {hi,data}; rs is taken from the LO strobe. Execute the byte, set byte_out, pulse cmd_valid or data_valid, return to HI.
- Commands (rs=0), decoded by highest set bit:
  - 1xxxxxxx Set DDRAM: addr = byte[6:0].
  - 01xxxxxx CGRAM: ignored, pulse only.
  - 001xxxxx Function Set: ignored, stays in 4-bit mode.
  - 0001xxxx Shift: ignored.
  - 00001DCB: display_on = D.
  - 000001IS: increment = I; shift ignored.
  - 0000001x Home: addr = 0.
  - 00000001 Clear: all 32 cells = FILL_CHAR, addr = 0, increment = 1, in the same cycle.
  - 8'h00: no operation, pulse only.
- Data (rs=1):
  - addr 0x00..0x0F: write line1[addr]. Char index n occupies bits [127-8n -: 8].
  - addr LINE2_BASE..LINE2_BASE+15: write line2[addr-LINE2_BASE].
  - Any other address: write discarded.
  - addr then moves by ±1 per the increment bit, with HD44780 wrap: 0x27 +1 → 0x40, 0x67 +1 → 0x00, 0x00 −1 → 0x67, 0x40 −1 → 0x27.
- A Set DDRAM to an invisible address is legal; later writes are discarded until the address wraps into a visible range.
- Reset between the HI and LO nibbles: the partial byte is lost, the FSM restarts in INIT8, and four_bit returns to 0.
- The strobe and an asynchronous reset assertion cannot collide: reset dominates.
- lcd_e held high or held low indefinitely produces no strobes.

Test Plan:
- Power-up sequence: nibbles 3,3,3,2 (rs=0) → four_bit=1, FSM in HI, no pulses, both lines all 8'h20.
- Init sequence: byte pairs 2/8, 0/6, 0/C, 0/1, 8/0 → five cmd_valid pulses; byte_out ends at 8'h80; display_on=1; addr=0.
- Data write: 16 data bytes "ABCDEFGHIJKLMNOP", then command C/0, then 16 bytes "0123456789abcdef":
  - line1 = 128'h4142…4F50
  - line2 = 128'h3031…6566
  - addr = 7'h50
- Wrap and discard: set addr 0x27, write 'X' → discarded, addr=0x40; write 'Y' → line2[127:120]=8'h59.
- Mid-byte reset and read strobe: after the high nibble 4, pulse rst_n low → lines refilled with 8'h20, four_bit=0. A strobe with lcd_w=1 → rd_err=1 and the FSM state is unchanged.
- Clear after content: load both lines, send 0/1 → all 256 bits = 8'h20 pattern on the next cycle, addr=0.

Source files
------------

// File: rtl/lcd_rx_decoder.sv
// lcd_rx_decoder: receive side of the 4-bit HD44780-style write bus.
// Captures a nibble on each falling edge of lcd_e. After the 8-bit power-up
// sequence it pairs nibbles into bytes, executes the driver's command subset
// and keeps a shadow DDRAM of two 16-character lines.
module lcd_rx_decoder #(
   parameter logic [7:0] FILL_CHAR  = 8'h20,
   parameter logic [6:0] LINE2_BASE = 7'h40
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         lcd_rs,
   input  logic         lcd_w,
   input  logic         lcd_e,
   input  logic [3:0]   data,
   output logic [127:0] line1,
   output logic [127:0] line2,
   output logic [6:0]   addr,
   output logic         display_on,
   output logic         four_bit,
   output logic [7:0]   byte_out,
   output logic         cmd_valid,
   output logic         data_valid,
   output logic         rd_err
);

   localparam logic [1:0] ST_INIT8 = 2'd0;
   localparam logic [1:0] ST_HI    = 2'd1;
   localparam logic [1:0] ST_LO    = 2'd2;

   logic [1:0] state;
   logic       e_q;
   logic [3:0] hi_nib;
   logic       incr;
   logic [7:0] l1 [16];
   logic [7:0] l2 [16];

   logic       strobe;
   logic       byte_done;
   logic [7:0] byte_w;
   logic [6:0] l2_off;
   logic       wr1, wr2, clr;
   logic [6:0] addr_inc, addr_dec, addr_step;

   // Falling edge of lcd_e; inputs are already synchronous to clk
   assign strobe    = e_q & ~lcd_e;
   assign byte_done = strobe & ~lcd_w & (state == ST_LO);
   assign byte_w    = {hi_nib, data};
   assign l2_off    = addr - LINE2_BASE;

   assign wr1 = byte_done & lcd_rs & (addr < 7'h10);
   assign wr2 = byte_done & lcd_rs & (addr >= LINE2_BASE) & (l2_off < 7'h10);
   assign clr = byte_done & ~lcd_rs & (byte_w == 8'h01);

   // HD44780 address counter stepping with the two-line wrap points
   always_comb begin
      addr_inc = addr + 7'd1;
      addr_dec = addr - 7'd1;
      if (addr == 7'h27) addr_inc = 7'h40;
      if (addr == 7'h67) addr_inc = 7'h00;
      if (addr == 7'h00) addr_dec = 7'h67;
      if (addr == 7'h40) addr_dec = 7'h27;
      addr_step = incr ? addr_inc : addr_dec;
   end

   // Shadow DDRAM cells: fill on reset and Clear, else write the addressed cell
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            l1[i] <= FILL_CHAR;
            l2[i] <= FILL_CHAR;
         end
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (clr) begin
               l1[i] <= FILL_CHAR;
               l2[i] <= FILL_CHAR;
            end else begin
               if (wr1 && addr[3:0] == 4'(i)) l1[i] <= byte_w;
               if (wr2 && l2_off[3:0] == 4'(i)) l2[i] <= byte_w;
            end
         end
      end
   end

   // Char 0 sits in the most significant byte of each line
   for (genvar g = 0; g < 16; g++) begin : g_pack
      assign line1[127-8*g -: 8] = l1[g];
      assign line2[127-8*g -: 8] = l2[g];
   end

   // Nibble FSM, command execution and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_INIT8;
         e_q        <= 1'b0;
         hi_nib     <= 4'h0;
         incr       <= 1'b1;
         addr       <= 7'h00;
         display_on <= 1'b0;
         four_bit   <= 1'b0;
         byte_out   <= 8'h00;
         cmd_valid  <= 1'b0;
         data_valid <= 1'b0;
         rd_err     <= 1'b0;
      end else begin
         e_q        <= lcd_e;
         cmd_valid  <= 1'b0;
         data_valid <= 1'b0;
         if (strobe) begin
            if (lcd_w) begin
               // reads are not supported; flag and leave the FSM alone
               rd_err <= 1'b1;
            end else begin
               case (state)
                  ST_INIT8: begin
                     // 8'h30 keeps 8-bit mode, 8'h20 switches to nibbles
                     if (!lcd_rs && data == 4'h2) begin
                        four_bit <= 1'b1;
                        state    <= ST_HI;
                     end
                  end
                  ST_HI: begin
                     hi_nib <= data;
                     state  <= ST_LO;
                  end
                  ST_LO: begin
                     state    <= ST_HI;
                     byte_out <= byte_w;
                     if (lcd_rs) begin
                        data_valid <= 1'b1;
                        addr       <= addr_step;
                     end else begin
                        cmd_valid <= 1'b1;
                        casez (byte_w)
                           8'b1???????: addr       <= byte_w[6:0];
                           8'b01??????: ;
                           8'b001?????: ;
                           8'b0001????: ;
                           8'b00001???: display_on <= byte_w[2];
                           8'b000001??: incr       <= byte_w[1];
                           8'b0000001?: addr       <= 7'h00;
                           8'b00000001: begin
                              addr <= 7'h00;
                              incr <= 1'b1;
                           end
                           default: ;
                        endcase
                     end
                  end
                  default: state <= ST_INIT8;
               endcase
            end
         end
      end
   end

endmodule
